// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_arb_pkg
// Purpose  : Shared types and constants for the FIFO write arbiter slice.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_arb_pkg;

    // Arbiter lock state: ARB = no requester locked, LOCK = owner holds the FIFO
    typedef enum logic [0:0] {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    // Width of every statistics counter
    localparam int STAT_W = 32;

    // Beat counter width; covers burst lengths up to 16
    localparam int CNT_W  = 5;

endpackage : fifo_arb_pkg
`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational rotating-priority search. Returns the first
//            asserted request strictly after index 'last', wrapping round.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int IDX_W = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic             valid,
    output logic [IDX_W-1:0] index
);

    // Two passes keep every bit select constant: first the indices above
    // 'last', then the wrapped indices from 0 up to and including 'last'.
    always_comb begin
        valid = 1'b0;
        index = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (!valid && req[j] && (j > int'(last))) begin
                valid = 1'b1;
                index = IDX_W'(j);
            end
        end
        for (int j = 0; j < N_REQ; j++) begin
            if (!valid && req[j] && (j <= int'(last))) begin
                valid = 1'b1;
                index = IDX_W'(j);
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Purpose  : Round-robin write arbiter for a shared FIFO with burst locking.
//            Grants, write strobe and write data are zero-latency combinational
//            outputs; the lock state, beat count and priority pointer are
//            registered.
// Options  : define ARB_STATS_EN to add beat_cnt / stall_cnt statistics.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int WIDTH = 8,
    parameter int BURST = 4
) (
    input  logic                       ap_clk,
    input  logic                       ap_rst_n,
    input  logic                       en,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*WIDTH-1:0]     req_data,
    output logic [N_REQ-1:0]           gnt,
    output logic                       fifo_wr_en,
    output logic [WIDTH-1:0]           fifo_wr_data,
    input  logic                       fifo_full,
    output logic                       busy,
`ifdef ARB_STATS_EN
    output logic [N_REQ*STAT_W-1:0]    beat_cnt,
    output logic [STAT_W-1:0]          stall_cnt,
`endif
    output logic [$clog2(N_REQ)-1:0]   owner
);

    localparam int IDX_W = $clog2(N_REQ);

    arb_state_e         state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [IDX_W-1:0]   last_q,  last_d;
    logic [IDX_W-1:0]   owner_q, owner_d;

    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic               use_arb;
    logic               grant;
    logic               grant_new;
    logic [IDX_W-1:0]   grant_idx;

    // 'last' is moved to the grantee as soon as a lock is taken, so a released
    // or aborted lock always resumes the scan from owner+1.
    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req   (req),
        .last  (last_q),
        .valid (pick_valid),
        .index (pick_idx)
    );

    // Decide this cycle's beat: locked owner if still requesting, else a new pick
    always_comb begin
        use_arb   = (state_q == ARB) || !req[owner_q];
        grant     = 1'b0;
        grant_new = 1'b0;
        grant_idx = owner_q;
        if (ap_rst_n && en && !fifo_full) begin
            if (!use_arb) begin
                grant     = 1'b1;
                grant_idx = owner_q;
            end else if (pick_valid) begin
                grant     = 1'b1;
                grant_new = 1'b1;
                grant_idx = pick_idx;
            end
        end
    end

    // State register with asynchronous reset; requester 0 has first priority
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= ARB;
            count_q <= '0;
            last_q  <= IDX_W'(N_REQ - 1);
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            last_q  <= last_d;
            owner_q <= owner_d;
        end
    end

    // Next-state logic for lock, beat count and priority pointer
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        last_d  = last_q;
        owner_d = owner_q;
        if (!en) begin
            state_d = ARB;
            count_d = '0;
        end else if (grant_new) begin
            owner_d = grant_idx;
            last_d  = grant_idx;
            count_d = CNT_W'(1);
            state_d = (BURST > 1) ? LOCK : ARB;
        end else if (grant) begin
            count_d = count_q + CNT_W'(1);
            if (count_q + CNT_W'(1) == CNT_W'(BURST)) begin
                state_d = ARB;
            end
        end else if (use_arb) begin
            // Owner dropped its request (or no lock held) and nothing was granted
            state_d = ARB;
        end
    end

    // Output decode: one-hot grant, write strobe and muxed write data
    always_comb begin
        gnt          = '0;
        fifo_wr_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant && (grant_idx == IDX_W'(i))) begin
                gnt[i]       = 1'b1;
                fifo_wr_data = req_data[i*WIDTH +: WIDTH];
            end
        end
        fifo_wr_en = grant;
        busy       = (state_q == LOCK);
        owner      = owner_q;
    end

`ifdef ARB_STATS_EN
    logic [STAT_W-1:0] stall_q;

    // Count cycles where someone wants to write but the FIFO is full
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            stall_q <= '0;
        end else if (en && (|req) && fifo_full) begin
            stall_q <= stall_q + STAT_W'(1);
        end
    end
    assign stall_cnt = stall_q;

    for (genvar g = 0; g < N_REQ; g++) begin : g_beat
        logic [STAT_W-1:0] beat_q;

        // Per-requester count of accepted beats
        always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
                beat_q <= '0;
            end else if (gnt[g]) begin
                beat_q <= beat_q + STAT_W'(1);
            end
        end
        assign beat_cnt[g*STAT_W +: STAT_W] = beat_q;
    end : g_beat
`endif

endmodule : fifo_wr_arbiter
`default_nettype wire
